regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback sources.
- Requester 0 is the in-order pipeline writeback (normal priority winner); requester 1 is the multi-cycle unit (load/mul/div return).
- Fixed priority to requester 0, with a starvation counter that forces a requester-1 grant after a bounded wait.
- Drives a registered write port (wr_en/wr_addr/wr_data) that connects directly to the register file.

Parameters:
- AW, 5, register address width
- DW, 32, register data width
- STARVE_LIMIT, 4, consecutive lost cycles after which requester 1 is forced through (legal range 1..15)
- ZERO_REG_RO, 1, when 1 writes to address 0 are accepted but never drive wr_en

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous; clears the starvation counter and cancels the output write staged this cycle
- req0_valid  in  1  pipeline writeback request
- req0_ready  out  1  requester 0 accepted when valid&ready
- req0_addr  in  AW  destination register
- req0_data  in  DW  write data
- req1_valid  in  1  multi-cycle unit request
- req1_ready  out  1  requester 1 accepted when valid&ready
- req1_addr  in  AW  destination register
- req1_data  in  DW  write data
- wr_en  out  1  register file write enable
- wr_addr  out  AW  register file write address
- wr_data  out  DW  register file write data
- force1  out  1  starvation override active (observability; the pipeline may use it to stall)

Behaviour:
- Reset (async, rst=1):
  - wr_en=0, wr_addr=0, wr_data=0.
  - starve_cnt=0, force1=0.
  - The ready outputs follow the combinational rules below; with cnt=0, req0_ready=1.
- Counter:
  - starve_cnt is 4 bits and saturates at STARVE_LIMIT.
  - force1 = (starve_cnt == STARVE_LIMIT), combinational from the registered count.
- Grant (combinational, evaluated each cycle):
  - force1=0: req0_ready=1; req1_ready = ~req0_valid.
  - force1=1: req0_ready=0; req1_ready=1.
  - At most one handshake occurs per cycle. Never grant both.
- Counter update at posedge, priority order:
  1. flush → 0.
  2. Requester-1 handshake → 0.
  3. req1_valid & ~req1_ready → +1 (saturating).
  4. req1_valid=0 → 0.
- Output stage (1-cycle latency):
  - The handshake at edge N produces wr_en=1 with the captured addr/data during cycle N+1.
  - The register file writes at the falling edge inside that cycle.
  - wr_en=0 in any cycle following an edge with no handshake.
  - wr_addr/wr_data hold their last value when wr_en=0.
- Zero register: with ZERO_REG_RO=1, a handshake with addr=0 completes normally (ready honoured, counter rules apply) but wr_en stays 0.
- Flush:
  - A handshake in the flush cycle still completes (ready is not gated by flush), but its write is discarded (wr_en=0 next cycle).
  - The counter clears.
- Simultaneous valids with force1=0: requester 0 wins, and the requester-1 counter increments.
- Reset asserted mid-operation: a pending output write is lost and the counter clears immediately (asynchronously).
- Requesters must hold valid/addr/data stable until the handshake; the arbiter does not check this.
- Arbitration latency bound: requester 1 waits at most STARVE_LIMIT cycles.

Test Plan:
1. Reset then idle: rst pulse → wr_en=0, force1=0, req0_ready=1, req1_ready=1 for 3 idle cycles.
2. Single writes:
   - req0 {addr=5, data=0xDEADBEEF} for 1 cycle → next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF; following cycle wr_en=0.
   - req1 {addr=7, data=0x1234} alone → same 1-cycle latency.
3. Starvation: req0_valid=1 continuously, req1 {addr=9, data=0xAA} valid from cycle 0, STARVE_LIMIT=4:
   - req1_ready=0 for cycles 0-3.
   - force1=1 and req1_ready=1 and req0_ready=0 in cycle 4; wr_addr=9 in cycle 5.
   - req0 resumes winning in cycle 5.
4. Zero register: req0 addr=0, data=0xFFFF → handshake occurs, wr_en stays 0. Repeat with ZERO_REG_RO=0 → wr_en=1, wr_addr=0.
5. Flush:
   - req0 handshake with flush=1 in the same cycle → wr_en=0 next cycle.
   - Counter at 3 with flush → counter 0, force1 not asserted in the following cycle.
6. Async reset mid-operation: assert rst between edges while wr_en=1 → wr_en=0 and force1=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: requester 0 (pipeline writeback) has fixed priority,
// requester 1 (multi-cycle unit) is forced through after STARVE_LIMIT consecutive losses.
module regfile_wb_arbiter #(
  parameter int AW           = 5,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter bit ZERO_REG_RO  = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          force1
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]    starve_cnt;
  logic [3:0]    cnt_next;
  logic          hs0;
  logic          hs1;
  logic          wr_next;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  assign force1 = (starve_cnt == LIMIT);

  always_comb begin
    req0_ready = ~force1;
    req1_ready = force1 | ~req0_valid;
    hs0        = req0_valid & req0_ready;
    hs1        = req1_valid & req1_ready;
    sel_addr   = hs1 ? req1_addr : req0_addr;
    sel_data   = hs1 ? req1_data : req0_data;
    // flushed and read-only zero-register writes still handshake but never reach the port
    wr_next    = (hs0 | hs1) & ~flush & ~(ZERO_REG_RO && (sel_addr == '0));
  end

  always_comb begin
    cnt_next = '0;
    if (flush || hs1) begin
      cnt_next = '0;
    end else if (req1_valid) begin
      cnt_next = (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      starve_cnt <= cnt_next;
      wr_en      <= wr_next;
      if (wr_next) begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single writes, starvation override,
// zero-register handling (both parameter settings), flush and asynchronous reset.
module tb_regfile_wb_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          req0_valid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req1_valid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;

  logic          req0_ready, req1_ready, wr_en, force1;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  logic          b_req0_ready, b_req1_ready, b_wr_en, b_force1;
  logic [AW-1:0] b_wr_addr;
  logic [DW-1:0] b_wr_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4), .ZERO_REG_RO(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .force1(force1)
  );

  regfile_wb_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4), .ZERO_REG_RO(1'b0)) dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(b_req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(b_req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .force1(b_force1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;

    // 1. reset then idle
    #12;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_force1", force1, 0);
    chk("rst_req0_ready", req0_ready, 1);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("idle_wr_en", wr_en, 0);
      chk("idle_force1", force1, 0);
      chk("idle_req0_ready", req0_ready, 1);
      chk("idle_req1_ready", req1_ready, 1);
      tick();
    end

    // 2. single writes
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
    #1 chk("w0_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("w0_wr_en", wr_en, 1);
    chk("w0_wr_addr", wr_addr, 5);
    chk("w0_wr_data", wr_data, 32'hDEADBEEF);
    tick();
    chk("w0_wr_en_off", wr_en, 0);
    chk("w0_addr_hold", wr_addr, 5);
    chk("w0_data_hold", wr_data, 32'hDEADBEEF);

    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h1234;
    #1 chk("w1_ready", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    #1;
    chk("w1_wr_en", wr_en, 1);
    chk("w1_wr_addr", wr_addr, 7);
    chk("w1_wr_data", wr_data, 32'h1234);
    tick();
    chk("w1_wr_en_off", wr_en, 0);

    // 3. starvation: req0 always valid, req1 forced through in cycle 4
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h33;
    req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'hAA;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("starve_req1_ready", req1_ready, 0);
      chk("starve_req0_ready", req0_ready, 1);
      chk("starve_force1", force1, 0);
      if (c > 0) begin
        chk("starve_wr_en", wr_en, 1);
        chk("starve_wr_addr", wr_addr, 3);
      end
      tick();
    end
    #1;
    chk("force_force1", force1, 1);
    chk("force_req1_ready", req1_ready, 1);
    chk("force_req0_ready", req0_ready, 0);
    chk("force_wr_en", wr_en, 1);
    chk("force_wr_addr", wr_addr, 3);
    tick();
    req1_valid = 1'b0;
    #1;
    chk("forced_wr_en", wr_en, 1);
    chk("forced_wr_addr", wr_addr, 9);
    chk("forced_wr_data", wr_data, 32'hAA);
    chk("forced_force1_clr", force1, 0);
    chk("forced_req0_ready", req0_ready, 1);
    tick();
    chk("resume_wr_addr", wr_addr, 3);
    chk("resume_wr_en", wr_en, 1);
    req0_valid = 1'b0;
    tick();
    chk("resume_idle_wr_en", wr_en, 0);

    // 4. zero register
    req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'hFFFF;
    #1 chk("z_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("z_ro_wr_en", wr_en, 0);
    chk("z_ro_addr_hold", wr_addr, 3);
    chk("z_rw_wr_en", b_wr_en, 1);
    chk("z_rw_wr_addr", b_wr_addr, 0);
    chk("z_rw_wr_data", b_wr_data, 32'hFFFF);
    tick();

    // 5a. handshake during flush is discarded
    req0_valid = 1'b1; req0_addr = 5'd6; req0_data = 32'h66; flush = 1'b1;
    #1 chk("fl_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0; flush = 1'b0;
    #1;
    chk("fl_wr_en", wr_en, 0);
    chk("fl_wr_en_b", b_wr_en, 0);
    tick();

    // 5b. counter at 3 cleared by flush
    req0_valid = 1'b1; req0_addr = 5'd2; req0_data = 32'h22;
    req1_valid = 1'b1; req1_addr = 5'd10; req1_data = 32'hA0;
    tick(); tick(); tick();
    #1 chk("cnt3_force1", force1, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("flush_force1", force1, 0);
    chk("flush_req1_ready", req1_ready, 0);
    chk("flush_wr_en", wr_en, 0);
    tick(); tick(); tick();
    #1 chk("refill3_force1", force1, 0);
    tick();

    // 6. asynchronous reset while force1=1 and wr_en=1
    #1;
    chk("pre_rst_force1", force1, 1);
    chk("pre_rst_wr_en", wr_en, 1);
    chk("pre_rst_wr_addr", wr_addr, 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_wr_en", wr_en, 0);
    chk("arst_force1", force1, 0);
    chk("arst_wr_addr", wr_addr, 0);
    chk("arst_req0_ready", req0_ready, 1);
    #1;
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk("post_rst_wr_en", wr_en, 0);
    chk("post_rst_force1", force1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
